// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
// Module   : muldiv_sequencer_if
// Purpose  : Start/operand/result bundle between CPU control and the
//            iterative multiply/divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             mult;
  logic             div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             divzero;
  logic             high_we;
  logic             low_we;
  logic [WIDTH-1:0] high_out;
  logic [WIDTH-1:0] low_out;

  modport master (
    output mult, div, op_a, op_b,
    input  busy, done, divzero, high_we, low_we, high_out, low_out
  );

  modport slave (
    input  mult, div, op_a, op_b,
    output busy, done, divzero, high_we, low_we, high_out, low_out
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative signed multiply (shift/add) and divide (restoring)
//            engine, WIDTH iterations per operation, HI/LO result strobes.
//            Optional: define MULDIV_ZERO_SKIP_EN to finish zero-operand
//            operations in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic         clk,
  input  wire logic         reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_high_out;
  logic [WIDTH-1:0] r_low_out;
  logic             r_divzero;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic               w_skip;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_a_mag  = bus.op_a[WIDTH-1] ? (~bus.op_a + 1'b1) : bus.op_a;
  assign w_b_mag  = bus.op_b[WIDTH-1] ? (~bus.op_b + 1'b1) : bus.op_b;
  assign w_b_zero = (bus.op_b == '0);

`ifdef MULDIV_ZERO_SKIP_EN
  assign w_skip = bus.mult ? ((bus.op_a == '0) || w_b_zero)
                           : (bus.div && (bus.op_a == '0) && !w_b_zero);
`else
  assign w_skip = 1'b0;
`endif

  // Multiply: {r_hi, r_lo} is the accumulator, multiplier shifts out of r_lo.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_qbit      = ~w_div_diff[WIDTH];

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_sign_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quot_fix = r_sign_q ? (~r_lo + 1'b1) : r_lo;
  assign w_rem_fix  = r_sign_r ? (~r_hi + 1'b1) : r_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_high_out <= '0;
      r_low_out  <= '0;
      r_divzero  <= 1'b0;
    end else begin
      r_divzero <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_cnt <= '0;
          if (bus.mult || bus.div) begin
            if (w_skip) begin
              r_high_out <= '0;
              r_low_out  <= '0;
              r_state    <= c_DONE;
            end else if (bus.mult) begin
              r_is_div <= 1'b0;
              r_sign_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
              r_sign_r <= 1'b0;
              r_b      <= w_a_mag;
              r_hi     <= '0;
              r_lo     <= w_b_mag;
              r_state  <= c_RUN;
            end else if (w_b_zero) begin
              r_divzero <= 1'b1;
            end else begin
              r_is_div <= 1'b1;
              r_sign_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
              r_sign_r <= bus.op_a[WIDTH-1];
              r_b      <= w_b_mag;
              r_hi     <= '0;
              r_lo     <= w_a_mag;
              r_state  <= c_RUN;
            end
          end
        end
        c_RUN: begin
          if (r_is_div) begin
            r_hi <= w_qbit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_qbit};
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= c_FIX;
          end
        end
        c_FIX: begin
          if (r_is_div) begin
            r_high_out <= w_rem_fix;
            r_low_out  <= w_quot_fix;
          end else begin
            r_high_out <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_low_out  <= w_prod_fix[WIDTH-1:0];
          end
          r_state <= c_DONE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state == c_RUN) || (r_state == c_FIX);
  assign bus.done     = (r_state == c_DONE);
  assign bus.high_we  = (r_state == c_DONE);
  assign bus.low_we   = (r_state == c_DONE);
  assign bus.divzero  = r_divzero;
  assign bus.high_out = r_high_out;
  assign bus.low_out  = r_low_out;

endmodule

`default_nettype wire
